// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with a valid/ready handshake. MUL and DIV step one bit per cycle.
// Build option: define MC_ALU_DIV_EN to include the restoring divider; without it DIV reports div_err.
module mc_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             use_carry,
  input  logic [4:0]       status_in,
  input  logic [WIDTH-1:0] opnd0,
  input  logic [WIDTH-1:0] opnd1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       status_out,
  output logic             div_err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_MUL = 3'd5, OP_DIV = 3'd6;
`ifdef MC_ALU_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [2:0]       op_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r, opnd_r;
  logic [WIDTH-1:0] result_r, result_hi_r;
  logic [4:0]       status_r;
  logic             div_err_r;

  logic             carry_s, multi_s, quick_err_s;
  logic [WIDTH:0]   sum_s, dif_s, mul_sum_s;
  logic [WIDTH-1:0] quick_res_s, quick_hi_s;
  logic [4:0]       quick_st_s;
  logic [WIDTH-1:0] div_rem_s, div_quo_s, step_hi_s, step_lo_s;
  logic [4:0]       step_st_s;

  function automatic logic parity_even_f(input logic [7:0] v);
    return ~(^v);
  endfunction

  // Flag vector {CF, PF, ZF, SF, OF}
  function automatic logic [4:0] flags_f(input logic [WIDTH-1:0] res, input logic cf, input logic of);
    return {cf, parity_even_f(res[7:0]), (res == {WIDTH{1'b0}}), res[WIDTH-1], of};
  endfunction

  assign in_ready   = (state_r == ST_IDLE);
  assign out_valid  = (state_r == ST_DONE);
  assign result     = result_r;
  assign result_hi  = result_hi_r;
  assign status_out = status_r;
  assign div_err    = div_err_r;

  // Single-cycle results computed straight from the request, plus the multi-cycle decision
  always_comb begin
    carry_s     = use_carry & status_in[4];
    sum_s       = {1'b0, opnd0} + {1'b0, opnd1} + {{WIDTH{1'b0}}, carry_s};
    dif_s       = {1'b0, opnd0} - {1'b0, opnd1} - {{WIDTH{1'b0}}, carry_s};
    quick_res_s = {WIDTH{1'b0}};
    quick_hi_s  = {WIDTH{1'b0}};
    quick_st_s  = 5'b00000;
    quick_err_s = 1'b0;
    multi_s     = 1'b0;
    case (op)
      OP_ADD: begin
        quick_res_s = sum_s[WIDTH-1:0];
        quick_st_s  = flags_f(sum_s[WIDTH-1:0], sum_s[WIDTH],
                              (opnd0[WIDTH-1] == opnd1[WIDTH-1]) && (sum_s[WIDTH-1] != opnd0[WIDTH-1]));
      end
      OP_SUB: begin
        quick_res_s = dif_s[WIDTH-1:0];
        quick_st_s  = flags_f(dif_s[WIDTH-1:0], dif_s[WIDTH],
                              (opnd0[WIDTH-1] != opnd1[WIDTH-1]) && (dif_s[WIDTH-1] != opnd0[WIDTH-1]));
      end
      OP_OR: begin
        quick_res_s = opnd0 | opnd1;
        quick_st_s  = flags_f(opnd0 | opnd1, 1'b0, 1'b0);
      end
      OP_XOR: begin
        quick_res_s = opnd0 ^ opnd1;
        quick_st_s  = flags_f(opnd0 ^ opnd1, 1'b0, 1'b0);
      end
      OP_MUL: multi_s = 1'b1;
      OP_DIV: begin
        if (DIV_EN && (opnd1 != {WIDTH{1'b0}})) begin
          multi_s = 1'b1;
        end else begin
          quick_hi_s  = DIV_EN ? opnd0 : {WIDTH{1'b0}};
          quick_st_s  = status_in;
          quick_err_s = 1'b1;
        end
      end
      default: begin
        quick_res_s = opnd0 & opnd1;
        quick_st_s  = flags_f(opnd0 & opnd1, 1'b0, 1'b0);
      end
    endcase
  end

`ifdef MC_ALU_DIV_EN
  logic [WIDTH+1:0] div_trial_s;

  // Restoring divide step: hi_r holds the partial remainder, lo_r shifts dividend out and quotient in
  always_comb begin
    div_trial_s = {1'b0, hi_r, lo_r[WIDTH-1]} - {2'b00, opnd_r};
    if (div_trial_s[WIDTH+1]) begin
      div_rem_s = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
    end else begin
      div_rem_s = div_trial_s[WIDTH-1:0];
    end
    div_quo_s = {lo_r[WIDTH-2:0], ~div_trial_s[WIDTH+1]};
  end
`else
  assign div_rem_s = {WIDTH{1'b0}};
  assign div_quo_s = {WIDTH{1'b0}};
`endif

  // Shift-add multiply step and selection of the active iteration
  always_comb begin
    mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    if (op_r == OP_MUL) begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
      step_st_s = flags_f(step_lo_s, (step_hi_s != {WIDTH{1'b0}}), (step_hi_s != {WIDTH{1'b0}}));
    end else begin
      step_hi_s = div_rem_s;
      step_lo_s = div_quo_s;
      step_st_s = flags_f(div_quo_s, 1'b0, 1'b0);
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = multi_s ? ST_BUSY : ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration registers and held results
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r        <= 3'd0;
      cnt_r       <= {CW{1'b0}};
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      opnd_r      <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      status_r    <= 5'b00000;
      div_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            op_r   <= op;
            cnt_r  <= {CW{1'b0}};
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= (op == OP_MUL) ? opnd1 : opnd0;
            opnd_r <= (op == OP_MUL) ? opnd0 : opnd1;
            if (!multi_s) begin
              result_r    <= quick_res_s;
              result_hi_r <= quick_hi_s;
              status_r    <= quick_st_s;
              div_err_r   <= quick_err_s;
            end
          end
        end
        ST_BUSY: begin
          hi_r  <= step_hi_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST) begin
            result_r    <= step_lo_s;
            result_hi_r <= step_hi_s;
            status_r    <= step_st_s;
            div_err_r   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: directed and randomized checks of mc_alu against an arithmetic reference model.
module tb_mc_alu;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, use_carry, out_valid, out_ready, div_err;
  logic [2:0]   op;
  logic [4:0]   status_in, status_out;
  logic [W-1:0] opnd0, opnd1, result, result_hi;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  mc_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .use_carry(use_carry), .status_in(status_in), .opnd0(opnd0), .opnd1(opnd1),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .status_out(status_out), .div_err(div_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on wide integers
  task automatic model(input logic [2:0] mop, input logic muc, input logic [4:0] mst,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic [W-1:0] hi, output logic [4:0] st,
                       output logic derr, output int lat);
    longint sa, sb, sr, cl;
    logic [63:0] p, ua, ub;
    logic cf, of, div_en;
`ifdef MC_ALU_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    cl = (muc && mst[4]) ? 64'sd1 : 64'sd0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    hi = '0; cf = 1'b0; of = 1'b0; derr = 1'b0; lat = 1; res = '0; sr = 0;
    case (mop)
      3'd0: begin
        p = ua + ub + 64'(cl); res = p[31:0]; cf = (p > 64'hFFFF_FFFF);
        sr = sa + sb + cl; of = (sr > SMAX) || (sr < SMIN);
      end
      3'd1: begin
        p = ua - ub - 64'(cl); res = p[31:0]; cf = (ua < ub + 64'(cl));
        sr = sa - sb - cl; of = (sr > SMAX) || (sr < SMIN);
      end
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: begin
        p = ua * ub; res = p[31:0]; hi = p[63:32]; cf = (hi != 0); of = cf; lat = W + 1;
      end
      3'd6: begin
        if (div_en && b != 0) begin
          res = a / b; hi = a % b; lat = W + 1;
        end else begin
          res = '0; hi = div_en ? a : '0; derr = 1'b1;
        end
      end
      default: res = a & b;
    endcase
    if (derr) st = mst;
    else st = {cf, ($countones(res[7:0]) % 2 == 0), (res == 0), res[31], of};
  endtask

  task automatic do_op(input logic [2:0] o, input logic uc, input logic [4:0] st,
                       input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input string tag);
    logic [W-1:0] e_res, e_hi;
    logic [4:0]   e_st;
    logic         e_err;
    int           e_lat, lat;
    model(o, uc, st, a, b, e_res, e_hi, e_st, e_err, e_lat);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    op = o; use_carry = uc; status_in = st; opnd0 = a; opnd1 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      in_valid  = 1'($urandom_range(0, 1));
      op        = 3'($urandom_range(0, 7));
      opnd0     = $urandom;
      opnd1     = $urandom;
      status_in = 5'($urandom_range(0, 31));
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(e_lat));
    check({tag, " result"}, 64'(result), 64'(e_res));
    check({tag, " result_hi"}, 64'(result_hi), 64'(e_hi));
    check({tag, " status/div_err"}, 64'({status_out, div_err}), 64'({e_st, e_err}));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; op = 3'($urandom_range(0, 7)); opnd0 = $urandom; opnd1 = $urandom; out_ready = 1'b0;
      @(negedge clk);
      check({tag, " hold result"}, {result_hi, result}, {e_hi, e_res});
      check({tag, " hold ctl"}, 64'({out_valid, in_ready, div_err, status_out}),
            64'({1'b1, 1'b0, e_err, e_st}));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " release"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; use_carry = 1'b0;
    status_in = 5'd0; opnd0 = '0; opnd1 = '0;
    repeat (3) @(negedge clk);
    check("reset ctl", 64'({in_ready, out_valid, div_err, status_out}), 64'({1'b1, 1'b0, 1'b0, 5'd0}));
    check("reset data", {result_hi, result}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(3'd0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd1, 0, "add_wrap");
    do_op(3'd1, 1'b0, 5'd0, 32'h8000_0000, 32'd1, 0, "sub_ovf");
    do_op(3'd1, 1'b1, 5'b10000, 32'd5, 32'd2, 0, "sbb");
    do_op(3'd0, 1'b1, 5'b10000, 32'h7FFF_FFFF, 32'd0, 0, "adc_ovf");
    do_op(3'd5, 1'b0, 5'd0, 32'h0001_0000, 32'h0001_0000, 0, "mul_big");
    do_op(3'd6, 1'b0, 5'd0, 32'd100, 32'd7, 0, "div");
    do_op(3'd6, 1'b0, 5'b01010, 32'd9, 32'd0, 0, "div0");
    do_op(3'd7, 1'b0, 5'd0, 32'hF0F0_1234, 32'h0FF0_FF0F, 0, "reserved");
    do_op(3'd0, 1'b0, 5'd0, 32'd40, 32'd2, 3, "hold_add");
    do_op(3'd5, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, "hold_mul");

    // Abort a MUL partway through; reset wins over concurrent in_valid/out_ready
    op = 3'd5; opnd0 = 32'd1234; opnd1 = 32'd5678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op = 3'd0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("abort ctl", 64'({in_ready, out_valid, div_err, status_out}), 64'({1'b1, 1'b0, 1'b0, 5'd0}));
    check("abort data", {result_hi, result}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort no out_valid", 64'(seen), 64'd0);
    do_op(3'd0, 1'b0, 5'd0, 32'd2, 32'd3, 0, "add_after_rst");

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(0, 3)); end
        2: begin ra = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h8000_0000; rb = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'd1; end
        default: begin ra = $urandom; rb = 32'($urandom_range(0, 65535)); end
      endcase
      do_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ra, rb, $urandom_range(0, 2), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
